// File: rtl/cdb_arbiter_if.sv
// Producer-side handshakes and the broadcast CDB grouped into one bundle.
// The slave modport is the arbiter's view; master is the producers and consumers.
interface cdb_arbiter_if #(
  parameter int unsigned ROB_ID_W = 5,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 32
);
  logic                alu_valid;
  logic                alu_ready;
  logic [ROB_ID_W-1:0] alu_rob_id;
  logic [DATA_W-1:0]   alu_result;
  logic [ADDR_W-1:0]   alu_target_pc;
  logic                alu_jump_flag;

  logic                ls_valid;
  logic                ls_ready;
  logic [ROB_ID_W-1:0] ls_rob_id;
  logic [DATA_W-1:0]   ls_result;

  logic                cdb_valid;
  logic [ROB_ID_W-1:0] cdb_rob_id;
  logic [DATA_W-1:0]   cdb_result;
  logic [ADDR_W-1:0]   cdb_target_pc;
  logic                cdb_jump_flag;
  logic                cdb_src;

  modport master (
    output alu_valid, alu_rob_id, alu_result, alu_target_pc, alu_jump_flag,
    output ls_valid, ls_rob_id, ls_result,
    input  alu_ready, ls_ready,
    input  cdb_valid, cdb_rob_id, cdb_result, cdb_target_pc, cdb_jump_flag, cdb_src
  );

  modport slave (
    input  alu_valid, alu_rob_id, alu_result, alu_target_pc, alu_jump_flag,
    input  ls_valid, ls_rob_id, ls_result,
    output alu_ready, ls_ready,
    output cdb_valid, cdb_rob_id, cdb_result, cdb_target_pc, cdb_jump_flag, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-source FIFOs for ALU and load/store results,
// round-robin granted onto a registered CDB; flush clears everything in flight.
module cdb_arbiter #(
  parameter int unsigned ROB_ID_W   = 5,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic         flush,
  cdb_arbiter_if.slave bus
);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [ROB_ID_W-1:0] rob_id;
    logic [DATA_W-1:0]   result;
    logic [ADDR_W-1:0]   target_pc;
    logic                jump_flag;
  } cdb_ent_t;

  typedef struct packed {
    logic [ROB_ID_W-1:0] rob_id;
    logic [DATA_W-1:0]   result;
  } ls_ent_t;

  cdb_ent_t           alu_mem [FIFO_DEPTH];
  ls_ent_t            ls_mem  [FIFO_DEPTH];
  logic [PTR_W-1:0]   alu_wp, alu_rp, ls_wp, ls_rp;
  logic [CNT_W-1:0]   alu_cnt, ls_cnt;
  logic               last_grant;
  logic               cdb_valid_q;
  logic               cdb_src_q;
  cdb_ent_t           cdb_q;

  logic active, alu_ready, ls_ready, alu_push, ls_push;
  logic alu_ne, ls_ne, grant_ls, alu_pop, ls_pop;

  // Handshake and grant decisions all use the FIFO state at the start of the cycle
  assign active    = rdy & ~flush;
  assign alu_ready = active & (alu_cnt < CNT_W'(FIFO_DEPTH));
  assign ls_ready  = active & (ls_cnt  < CNT_W'(FIFO_DEPTH));
  assign alu_push  = alu_ready & bus.alu_valid & (bus.alu_rob_id != '0);
  assign ls_push   = ls_ready  & bus.ls_valid  & (bus.ls_rob_id  != '0);
  assign alu_ne    = (alu_cnt != '0);
  assign ls_ne     = (ls_cnt  != '0);
  assign grant_ls  = ls_ne & (~alu_ne | ~last_grant);
  assign alu_pop   = active & alu_ne & ~grant_ls;
  assign ls_pop    = active & grant_ls;

  // Payload storage needs no reset: occupancy is tracked by the counters
  always_ff @(posedge clk) begin
    if (alu_push) alu_mem[alu_wp] <= '{bus.alu_rob_id, bus.alu_result,
                                       bus.alu_target_pc, bus.alu_jump_flag};
    if (ls_push)  ls_mem[ls_wp]   <= '{bus.ls_rob_id, bus.ls_result};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_wp      <= '0;
      alu_rp      <= '0;
      alu_cnt     <= '0;
      ls_wp       <= '0;
      ls_rp       <= '0;
      ls_cnt      <= '0;
      last_grant  <= 1'b1;
      cdb_valid_q <= 1'b0;
      cdb_src_q   <= 1'b0;
      cdb_q       <= '0;
    end else if (flush) begin
      alu_wp      <= '0;
      alu_rp      <= '0;
      alu_cnt     <= '0;
      ls_wp       <= '0;
      ls_rp       <= '0;
      ls_cnt      <= '0;
      cdb_valid_q <= 1'b0;
    end else if (rdy) begin
      if (alu_push) alu_wp <= alu_wp + PTR_W'(1);
      if (alu_pop)  alu_rp <= alu_rp + PTR_W'(1);
      if (ls_push)  ls_wp  <= ls_wp + PTR_W'(1);
      if (ls_pop)   ls_rp  <= ls_rp + PTR_W'(1);
      alu_cnt <= alu_cnt + CNT_W'(alu_push) - CNT_W'(alu_pop);
      ls_cnt  <= ls_cnt + CNT_W'(ls_push) - CNT_W'(ls_pop);
      // Load/store results never carry a redirect, so pc and jump flag are zeroed
      if (alu_pop) begin
        cdb_valid_q <= 1'b1;
        cdb_src_q   <= 1'b0;
        cdb_q       <= alu_mem[alu_rp];
        last_grant  <= 1'b0;
      end else if (ls_pop) begin
        cdb_valid_q <= 1'b1;
        cdb_src_q   <= 1'b1;
        cdb_q       <= '{ls_mem[ls_rp].rob_id, ls_mem[ls_rp].result, '0, 1'b0};
        last_grant  <= 1'b1;
      end else begin
        cdb_valid_q <= 1'b0;
      end
    end
  end

  assign bus.alu_ready     = alu_ready;
  assign bus.ls_ready      = ls_ready;
  assign bus.cdb_valid     = cdb_valid_q;
  assign bus.cdb_rob_id    = cdb_q.rob_id;
  assign bus.cdb_result    = cdb_q.result;
  assign bus.cdb_target_pc = cdb_q.target_pc;
  assign bus.cdb_jump_flag = cdb_q.jump_flag;
  assign bus.cdb_src       = cdb_src_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus random traffic, all checked
// against a queue-based model of the two sources and the round-robin CDB.
module tb_cdb_arbiter;
  localparam int unsigned ROB_ID_W = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DEPTH    = 2;

  logic clk = 1'b0;
  logic rst, rdy, flush;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.ROB_ID_W(ROB_ID_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  cdb_arbiter #(.ROB_ID_W(ROB_ID_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
                .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .bus(bus)
  );

  typedef struct {
    logic [4:0]  id;
    logic [31:0] res;
    logic [31:0] pc;
    logic        jf;
  } ent_t;

  ent_t        aq[$];
  ent_t        lq[$];
  logic        m_valid, m_jf, m_src, m_last;
  logic [4:0]  m_id;
  logic [31:0] m_res, m_pc;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    aq.delete();
    lq.delete();
    m_valid = 1'b0; m_jf = 1'b0; m_src = 1'b0; m_last = 1'b1;
    m_id = '0; m_res = '0; m_pc = '0;
  endtask

  // One clock of stimulus, entered and left on the falling edge
  task automatic step(input logic r, input logic f,
                      input logic av, input logic [4:0] aid, input logic [31:0] ares,
                      input logic [31:0] apc, input logic ajf,
                      input logic lv, input logic [4:0] lid, input logic [31:0] lres);
    logic ear, elr;
    ent_t e;
    int   g;
    rdy = r; flush = f;
    bus.alu_valid = av; bus.alu_rob_id = aid; bus.alu_result = ares;
    bus.alu_target_pc = apc; bus.alu_jump_flag = ajf;
    bus.ls_valid = lv; bus.ls_rob_id = lid; bus.ls_result = lres;
    #1;
    ear = r & ~f & (aq.size() < int'(DEPTH));
    elr = r & ~f & (lq.size() < int'(DEPTH));
    chk("alu_ready", 64'(bus.alu_ready), 64'(ear));
    chk("ls_ready", 64'(bus.ls_ready), 64'(elr));
    if (f) begin
      aq.delete();
      lq.delete();
      m_valid = 1'b0;
    end else if (r) begin
      g = -1;
      if (aq.size() != 0 && lq.size() != 0) g = m_last ? 0 : 1;
      else if (aq.size() != 0) g = 0;
      else if (lq.size() != 0) g = 1;
      if (g == 0) begin
        e = aq.pop_front();
        m_valid = 1'b1; m_src = 1'b0; m_last = 1'b0;
        m_id = e.id; m_res = e.res; m_pc = e.pc; m_jf = e.jf;
      end else if (g == 1) begin
        e = lq.pop_front();
        m_valid = 1'b1; m_src = 1'b1; m_last = 1'b1;
        m_id = e.id; m_res = e.res; m_pc = '0; m_jf = 1'b0;
      end else begin
        m_valid = 1'b0;
      end
      if (av && ear && aid != 0) aq.push_back('{aid, ares, apc, ajf});
      if (lv && elr && lid != 0) lq.push_back('{lid, lres, 32'h0, 1'b0});
    end
    @(posedge clk);
    #1;
    chk("cdb_valid", 64'(bus.cdb_valid), 64'(m_valid));
    chk("cdb_rob_id", 64'(bus.cdb_rob_id), 64'(m_id));
    chk("cdb_result", 64'(bus.cdb_result), 64'(m_res));
    chk("cdb_target_pc", 64'(bus.cdb_target_pc), 64'(m_pc));
    chk("cdb_jump_flag", 64'(bus.cdb_jump_flag), 64'(m_jf));
    chk("cdb_src", 64'(bus.cdb_src), 64'(m_src));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b0; flush = 1'b0;
    bus.alu_valid = 1'b0; bus.alu_rob_id = '0; bus.alu_result = '0;
    bus.alu_target_pc = '0; bus.alu_jump_flag = 1'b0;
    bus.ls_valid = 1'b0; bus.ls_rob_id = '0; bus.ls_result = '0;
    #1 rst = 1'b0;
    model_reset();
    #1;
    chk("rst_valid", 64'(bus.cdb_valid), 64'(0));
    chk("rst_rob_id", 64'(bus.cdb_rob_id), 64'(0));
    chk("rst_result", 64'(bus.cdb_result), 64'(0));
    chk("rst_src", 64'(bus.cdb_src), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Single ALU result with a jump
    step(1, 0, 1, 3, 32'h11, 32'h40, 1, 0, 0, 0);
    idle(1);
    idle(1);

    // Simultaneous ALU and LS traffic alternates on the bus
    for (int i = 0; i < 3; i++) step(1, 0, 1, 1, 32'hA0 + i, 32'h100, 0, 1, 2, 32'hB0 + i);
    idle(4);

    // Back-to-back ALU pushes stream without bubbles
    for (int i = 0; i < 4; i++) step(1, 0, 1, 5'(4 + i), 32'hC0 + i, 32'h200 + i, 0, 0, 0, 0);
    idle(3);

    // Fill LS to full, freeze, then offer a push against a full FIFO
    step(1, 0, 1, 7, 32'h7, 32'h70, 0, 1, 8, 32'h8);
    step(1, 0, 1, 9, 32'h9, 32'h90, 1, 1, 10, 32'h10);
    step(0, 0, 0, 0, 0, 0, 0, 1, 12, 32'h12);
    step(0, 0, 0, 0, 0, 0, 0, 1, 12, 32'h12);
    step(1, 0, 0, 0, 0, 0, 0, 1, 11, 32'h11);
    step(1, 0, 0, 0, 0, 0, 0, 1, 11, 32'h11);
    idle(4);

    // Flush with both sources queued and the bus busy
    step(1, 0, 1, 13, 32'hD, 32'h13, 0, 1, 14, 32'hE);
    step(1, 0, 1, 15, 32'hF, 32'h15, 1, 1, 16, 32'h16);
    step(1, 0, 1, 17, 32'h17, 32'h17, 0, 1, 18, 32'h18);
    step(1, 1, 1, 19, 32'h19, 32'h19, 0, 1, 20, 32'h20);
    idle(4);

    // Null rob id is accepted but never appears on the bus
    step(1, 0, 1, 0, 32'hDEAD, 32'hBEEF, 1, 1, 0, 32'hCAFE);
    idle(2);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 4),
           ($urandom_range(0, 99) < 65), 5'($urandom_range(0, 31)), $urandom, $urandom,
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 99) < 65), 5'($urandom_range(0, 31)), $urandom);
    end

    // Asynchronous reset mid-stream, between clock edges
    step(1, 0, 1, 21, 32'h21, 32'h210, 1, 1, 22, 32'h22);
    step(1, 0, 1, 23, 32'h23, 32'h230, 0, 1, 24, 32'h24);
    #3 rst = 1'b0;
    #1;
    chk("async_valid", 64'(bus.cdb_valid), 64'(0));
    chk("async_rob_id", 64'(bus.cdb_rob_id), 64'(0));
    chk("async_result", 64'(bus.cdb_result), 64'(0));
    chk("async_pc", 64'(bus.cdb_target_pc), 64'(0));
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    idle(3);
    step(1, 0, 1, 25, 32'h25, 32'h250, 0, 1, 26, 32'h26);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
